// File: rtl/hcms_frame_ctrl.sv
// hcms_frame_ctrl: upstream sequencer for the hcms_serial byte sender.
// Runs the display power-up sequence: DS_RESET hold, then control word 0.
// Streams one frame of column bytes from an on-chip buffer per request,
// using a four-phase LOAD/READY handshake with a per-phase timeout.
//
// Ports:
//   CLK_i, nRST_i          clock, synchronous active-low reset
//   BRIGHT_i               PWM brightness for control word 0
//   WR_EN_i/ADDR_i/DATA_i  column buffer write port (out-of-range ignored)
//   UPDATE_i               frame transfer request pulse
//   BUSY_o, FRAME_DONE_o   status; ERR_o sticky handshake timeout flag
//   SER_*_o, SER_READY_i   byte sender interface
//
// Optional feature: define HCMS_AUTO_REFRESH_EN to add an IDLE refresh
// counter that requests a frame every 65536 idle cycles.
module hcms_frame_ctrl #(
  parameter int unsigned NUM_COLS     = 40,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter logic [1:0]  PEAK_CUR     = 2'b10
) (
  input  logic       CLK_i,
  input  logic       nRST_i,
  input  logic [3:0] BRIGHT_i,
  input  logic       WR_EN_i,
  input  logic [5:0] WR_ADDR_i,
  input  logic [7:0] WR_DATA_i,
  input  logic       UPDATE_i,
  output logic       BUSY_o,
  output logic       FRAME_DONE_o,
  output logic       ERR_o,
  output logic [7:0] SER_DATA_o,
  output logic       SER_LOAD_o,
  output logic       SER_CMD_o,
  output logic       SER_DSRESET_o,
  input  logic       SER_READY_i
);

  localparam int unsigned COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > RESET_CYCLES) ? ACK_TIMEOUT : RESET_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_CTRL_LD,
    ST_CTRL_ACK,
    ST_CTRL_REL,
    ST_IDLE,
    ST_DATA_LD,
    ST_DATA_ACK,
    ST_DATA_REL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             pending_q, pending_d;
  logic             frame_req_q, frame_req_d;
  logic [3:0]       last_bright_q, last_bright_d;
  logic [7:0]       data_q, data_d;
  logic             load_q, load_d;
  logic             cmd_q, cmd_d;
  logic             dsreset_q, dsreset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout_c;
  logic             abort_c;

  logic [7:0]       buf_q [NUM_COLS];
  logic             wr_hit_c;

`ifdef HCMS_AUTO_REFRESH_EN
  logic [15:0]      refresh_q, refresh_d;
`endif

  // Column buffer: writes accepted in every state, never reset
  assign wr_hit_c = WR_EN_i && ({1'b0, WR_ADDR_i} < 7'(NUM_COLS));

  always_ff @(posedge CLK_i) begin
    if (wr_hit_c) begin
      buf_q[WR_ADDR_i[COL_W-1:0]] <= WR_DATA_i;
    end
  end

  assign timeout_c = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    pending_d     = pending_q;
    frame_req_d   = frame_req_q;
    last_bright_d = last_bright_q;
    data_d        = data_q;
    load_d        = load_q;
    cmd_d         = cmd_q;
    dsreset_d     = dsreset_q;
    done_d        = 1'b0;
    err_d         = err_q;
    abort_c       = 1'b0;

    // Requests arriving while busy collapse into one pending frame
    if (UPDATE_i && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

`ifdef HCMS_AUTO_REFRESH_EN
    refresh_d = '0;
    if (state_q == ST_IDLE) begin
      if (refresh_q == 16'hFFFF) begin
        pending_d = 1'b1;
      end else begin
        refresh_d = refresh_q + 16'd1;
      end
    end
`endif

    unique case (state_q)
      ST_RST_HOLD: begin
        dsreset_d = 1'b1;
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          dsreset_d = 1'b0;
          state_d   = ST_CTRL_LD;
        end
      end
      ST_CTRL_LD: begin
        data_d        = {1'b0, 1'b1, PEAK_CUR, BRIGHT_i};
        cmd_d         = 1'b1;
        load_d        = 1'b1;
        last_bright_d = BRIGHT_i;
        state_d       = ST_CTRL_ACK;
      end
      ST_CTRL_ACK: begin
        if (SER_READY_i) begin
          load_d  = 1'b0;
          state_d = ST_CTRL_REL;
        end else if (timeout_c) begin
          abort_c = 1'b1;
        end
      end
      ST_CTRL_REL: begin
        if (!SER_READY_i) begin
          if (frame_req_q) begin
            frame_req_d = 1'b0;
            col_d       = '0;
            state_d     = ST_DATA_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_c) begin
          abort_c = 1'b1;
        end
      end
      ST_IDLE: begin
        if (UPDATE_i || pending_q) begin
          pending_d = 1'b0;
          // A brightness change is applied before the frame data
          if (BRIGHT_i != last_bright_q) begin
            frame_req_d = 1'b1;
            state_d     = ST_CTRL_LD;
          end else begin
            col_d   = '0;
            state_d = ST_DATA_LD;
          end
        end
      end
      ST_DATA_LD: begin
        data_d  = buf_q[col_q];
        cmd_d   = 1'b0;
        load_d  = 1'b1;
        state_d = ST_DATA_ACK;
      end
      ST_DATA_ACK: begin
        if (SER_READY_i) begin
          load_d  = 1'b0;
          state_d = ST_DATA_REL;
        end else if (timeout_c) begin
          abort_c = 1'b1;
        end
      end
      ST_DATA_REL: begin
        if (!SER_READY_i) begin
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_DATA_LD;
          end
        end else if (timeout_c) begin
          abort_c = 1'b1;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase

    // Handshake timeout: abort frame and rerun the full power-up sequence
    if (abort_c) begin
      err_d       = 1'b1;
      load_d      = 1'b0;
      pending_d   = 1'b0;
      frame_req_d = 1'b0;
      dsreset_d   = 1'b1;
      state_d     = ST_RST_HOLD;
    end

    // Wait counter restarts on every state entry
    cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    // Busy stays high through the FRAME_DONE cycle
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  always_ff @(posedge CLK_i) begin
    if (!nRST_i) begin
      state_q       <= ST_RST_HOLD;
      cnt_q         <= '0;
      col_q         <= '0;
      pending_q     <= 1'b0;
      frame_req_q   <= 1'b0;
      last_bright_q <= 4'h0;
      data_q        <= 8'h00;
      load_q        <= 1'b0;
      cmd_q         <= 1'b0;
      dsreset_q     <= 1'b1;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      pending_q     <= pending_d;
      frame_req_q   <= frame_req_d;
      last_bright_q <= last_bright_d;
      data_q        <= data_d;
      load_q        <= load_d;
      cmd_q         <= cmd_d;
      dsreset_q     <= dsreset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

`ifdef HCMS_AUTO_REFRESH_EN
  always_ff @(posedge CLK_i) begin
    if (!nRST_i) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_d;
    end
  end
`endif

  assign BUSY_o        = busy_q;
  assign FRAME_DONE_o  = done_q;
  assign ERR_o         = err_q;
  assign SER_DATA_o    = data_q;
  assign SER_LOAD_o    = load_q;
  assign SER_CMD_o     = cmd_q;
  assign SER_DSRESET_o = dsreset_q;

endmodule

// File: tb/tb_hcms_frame_ctrl.sv
// Testbench for hcms_frame_ctrl: stub byte sender with random latency,
// transaction-level expected-byte scoreboard, per-cycle handshake checks.
module tb_hcms_frame_ctrl;

  localparam int unsigned NCOLS = 40;

  logic       CLK_i = 1'b0;
  logic       nRST_i;
  logic [3:0] BRIGHT_i;
  logic       WR_EN_i;
  logic [5:0] WR_ADDR_i;
  logic [7:0] WR_DATA_i;
  logic       UPDATE_i;
  logic       BUSY_o;
  logic       FRAME_DONE_o;
  logic       ERR_o;
  logic [7:0] SER_DATA_o;
  logic       SER_LOAD_o;
  logic       SER_CMD_o;
  logic       SER_DSRESET_o;
  logic       SER_READY_i;

  hcms_frame_ctrl dut (
    .CLK_i         (CLK_i),
    .nRST_i        (nRST_i),
    .BRIGHT_i      (BRIGHT_i),
    .WR_EN_i       (WR_EN_i),
    .WR_ADDR_i     (WR_ADDR_i),
    .WR_DATA_i     (WR_DATA_i),
    .UPDATE_i      (UPDATE_i),
    .BUSY_o        (BUSY_o),
    .FRAME_DONE_o  (FRAME_DONE_o),
    .ERR_o         (ERR_o),
    .SER_DATA_o    (SER_DATA_o),
    .SER_LOAD_o    (SER_LOAD_o),
    .SER_CMD_o     (SER_CMD_o),
    .SER_DSRESET_o (SER_DSRESET_o),
    .SER_READY_i   (SER_READY_i)
  );

  always #5 CLK_i = ~CLK_i;

  typedef struct {
    logic       cmd;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] cap_q[$];
  logic       cap_cmd_q[$];
  logic [7:0] mdl_buf [NCOLS];
  logic [3:0] mdl_bright;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         load_rise_cyc = 0;
  logic       done_expected = 1'b0;
  logic       prev_load = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] held_data;
  logic       held_cmd;

  int         lat_cfg = 9;
  bit         stall_en = 1'b0;
  logic [7:0] stall_val = 8'h00;
  int         s_cnt = 0, s_lat = 9, r_cnt = 0, r_lat = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge CLK_i) cyc++;

  // Stub byte sender: READY after a latency while LOAD high, drops after LOAD falls
  always @(posedge CLK_i) begin
    #1;
    if (!nRST_i) begin
      SER_READY_i = 1'b0;
      s_cnt = 0;
      r_cnt = 0;
    end else if (!SER_READY_i) begin
      r_cnt = 0;
      if (SER_LOAD_o && !(stall_en && !SER_CMD_o && SER_DATA_o == stall_val)) begin
        s_cnt++;
        if (s_cnt >= s_lat) begin
          SER_READY_i = 1'b1;
          s_cnt = 0;
          s_lat = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 12));
        end
      end else begin
        s_cnt = 0;
      end
    end else if (!SER_LOAD_o) begin
      r_cnt++;
      if (r_cnt >= r_lat) begin
        SER_READY_i = 1'b0;
        r_cnt = 0;
        r_lat = int'($urandom_range(1, 3));
      end
    end
  end

  // Compare process: scoreboard on each LOAD rise, handshake invariants every cycle
  always @(negedge CLK_i) begin
    if (!nRST_i) begin
      prev_load     = 1'b0;
      prev_err      = 1'b0;
      done_expected = 1'b0;
    end else begin
      if (SER_LOAD_o && !prev_load) begin
        load_rise_cyc = cyc;
        cap_q.push_back(SER_DATA_o);
        cap_cmd_q.push_back(SER_CMD_o);
        chk("done_before_next_load", 32'(done_expected), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load actual=%0h required=none", SER_DATA_o);
        end else begin
          e = exp_q.pop_front();
          chk("load_cmd", 32'(SER_CMD_o), 32'(e.cmd));
          chk("load_data", 32'(SER_DATA_o), 32'(e.data));
          if (e.last) done_expected = 1'b1;
        end
        held_data = SER_DATA_o;
        held_cmd  = SER_CMD_o;
      end else if (SER_LOAD_o) begin
        chk("data_stable", 32'(SER_DATA_o), 32'(held_data));
        chk("cmd_stable", 32'(SER_CMD_o), 32'(held_cmd));
      end
      if (FRAME_DONE_o) begin
        chk("frame_done_expected", 32'(done_expected), 32'd1);
        done_expected = 1'b0;
        done_cnt++;
      end
      if (prev_err) chk("err_sticky", 32'(ERR_o), 32'd1);
      if (SER_LOAD_o || SER_DSRESET_o) chk("busy_when_active", 32'(BUSY_o), 32'd1);
      prev_load = SER_LOAD_o;
      prev_err  = ERR_o;
    end
  end

  task automatic push_ctrl(input logic [3:0] b);
    exp_q.push_back('{cmd: 1'b1, data: {4'b0110, b}, last: 1'b0});
  endtask

  task automatic push_frame();
    for (int i = 0; i < NCOLS; i++)
      exp_q.push_back('{cmd: 1'b0, data: mdl_buf[i], last: (i == NCOLS - 1)});
  endtask

  task automatic write_col(input logic [5:0] a, input logic [7:0] d);
    @(negedge CLK_i);
    WR_EN_i = 1'b1; WR_ADDR_i = a; WR_DATA_i = d;
    @(negedge CLK_i);
    WR_EN_i = 1'b0;
    if (int'(a) < NCOLS) mdl_buf[a] = d;
  endtask

  task automatic pulse_update();
    @(negedge CLK_i);
    UPDATE_i = 1'b1;
    @(negedge CLK_i);
    UPDATE_i = 1'b0;
  endtask

  task automatic start_frame();
    if (BRIGHT_i != mdl_bright) begin
      push_ctrl(BRIGHT_i);
      mdl_bright = BRIGHT_i;
    end
    push_frame();
    pulse_update();
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    @(negedge CLK_i);
    while (!(exp_q.size() == 0 && !BUSY_o && !SER_DSRESET_o) && n < limit) begin
      @(negedge CLK_i);
      n++;
    end
    chk({name, "_reach_idle"}, 32'(n < limit), 32'd1);
    chk({name, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cap(input int cnt, input int limit);
    int n = 0;
    while (cap_q.size() < cnt && n < limit) begin
      @(negedge CLK_i);
      n++;
    end
    chk("wait_loads", 32'(n < limit), 32'd1);
  endtask

  task automatic count_dsreset(input string name);
    int n = 0;
    while (SER_DSRESET_o && n < 100) begin
      n++;
      @(negedge CLK_i);
    end
    chk(name, 32'(n), 32'd16);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    nRST_i = 1'b0; BRIGHT_i = 4'h7; WR_EN_i = 1'b0; WR_ADDR_i = '0;
    WR_DATA_i = '0; UPDATE_i = 1'b0; SER_READY_i = 1'b0;
    mdl_bright = 4'h0;
    for (int i = 0; i < NCOLS; i++) mdl_buf[i] = 8'h00;

    // Power-up: reset values, DS_RESET hold, control word 0x67
    repeat (2) @(posedge CLK_i);
    @(negedge CLK_i);
    chk("rst_load", 32'(SER_LOAD_o), 32'd0);
    chk("rst_cmd", 32'(SER_CMD_o), 32'd0);
    chk("rst_data", 32'(SER_DATA_o), 32'h00);
    chk("rst_dsreset", 32'(SER_DSRESET_o), 32'd1);
    chk("rst_busy", 32'(BUSY_o), 32'd1);
    chk("rst_done", 32'(FRAME_DONE_o), 32'd0);
    chk("rst_err", 32'(ERR_o), 32'd0);
    push_ctrl(4'h7);
    mdl_bright = 4'h7;
    nRST_i = 1'b1;
    count_dsreset("powerup_dsreset_cycles");
    wait_idle("powerup", 200);
    chk("powerup_loads", 32'(cap_q.size()), 32'd1);
    chk("powerup_ctrl_byte", 32'(cap_q[0]), 32'h67);
    chk("powerup_ctrl_cmd", 32'(cap_cmd_q[0]), 32'd1);
    chk("powerup_busy", 32'(BUSY_o), 32'd0);

    // Frame of i+1, FRAME_DONE then BUSY falls next cycle
    for (int i = 0; i < NCOLS; i++) write_col(6'(i), 8'(i + 1));
    cap_q.delete(); cap_cmd_q.delete();
    d0 = done_cnt;
    start_frame();
    n = 0;
    while (!FRAME_DONE_o && n < 2000) begin @(negedge CLK_i); n++; end
    chk("frame1_done_seen", 32'(FRAME_DONE_o), 32'd1);
    @(negedge CLK_i);
    chk("frame1_busy_after_done", 32'(BUSY_o), 32'd0);
    wait_idle("frame1", 200);
    chk("frame1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("frame1_loads", 32'(cap_q.size()), 32'd40);
    chk("frame1_first", 32'(cap_q[0]), 32'h01);
    chk("frame1_last", 32'(cap_q[39]), 32'h28);

    // Brightness change: control byte first, then data
    BRIGHT_i = 4'hF;
    cap_q.delete(); cap_cmd_q.delete();
    start_frame();
    wait_idle("bright", 3000);
    chk("bright_loads", 32'(cap_q.size()), 32'd41);
    chk("bright_ctrl_byte", 32'(cap_q[0]), 32'h6F);
    chk("bright_ctrl_cmd", 32'(cap_cmd_q[0]), 32'd1);
    cap_q.delete(); cap_cmd_q.delete();
    start_frame();
    wait_idle("same_bright", 3000);
    chk("same_bright_loads", 32'(cap_q.size()), 32'd40);
    chk("same_bright_first_cmd", 32'(cap_cmd_q[0]), 32'd0);

    // Triple UPDATE during a frame plus an out-of-range write -> one extra frame
    lat_cfg = 0;
    cap_q.delete(); cap_cmd_q.delete();
    d0 = done_cnt;
    push_frame();
    start_frame();
    wait_cap(3, 500);
    repeat (3) begin
      pulse_update();
      @(negedge CLK_i);
    end
    write_col(6'd50, 8'hAA);
    wait_idle("pending", 5000);
    chk("pending_done_count", 32'(done_cnt - d0), 32'd2);
    chk("pending_loads", 32'(cap_q.size()), 32'd80);

    // Randomized buffer contents and brightness
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NCOLS; i++) write_col(6'(i), 8'($urandom));
      BRIGHT_i = 4'($urandom);
      d0 = done_cnt;
      start_frame();
      wait_idle("random", 5000);
      chk("random_done_count", 32'(done_cnt - d0), 32'd1);
    end

    // Stall on column 5: timeout, error, full re-init, no FRAME_DONE
    for (int i = 0; i < NCOLS; i++) write_col(6'(i), 8'(i + 1));
    stall_val = 8'h06;
    stall_en  = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back('{cmd: 1'b0, data: mdl_buf[i], last: 1'b0});
    push_ctrl(mdl_bright);
    pulse_update();
    n = 0;
    while (!ERR_o && n < 3000) begin @(negedge CLK_i); n++; end
    chk("timeout_err", 32'(ERR_o), 32'd1);
    chk("timeout_cycles", 32'(cyc - load_rise_cyc), 32'd1024);
    chk("timeout_load_low", 32'(SER_LOAD_o), 32'd0);
    stall_en = 1'b0;
    count_dsreset("timeout_dsreset_cycles");
    wait_idle("timeout", 500);
    chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    chk("timeout_err_held", 32'(ERR_o), 32'd1);

    // Reset mid-frame: no FRAME_DONE, error cleared, re-init
    d0 = done_cnt;
    cap_q.delete(); cap_cmd_q.delete();
    start_frame();
    wait_cap(3, 500);
    @(posedge CLK_i); #1;
    nRST_i = 1'b0;
    @(posedge CLK_i); #1;
    exp_q.delete();
    push_ctrl(BRIGHT_i);
    nRST_i = 1'b1;
    @(negedge CLK_i);
    chk("midrst_err", 32'(ERR_o), 32'd0);
    chk("midrst_load", 32'(SER_LOAD_o), 32'd0);
    chk("midrst_dsreset", 32'(SER_DSRESET_o), 32'd1);
    wait_idle("midrst", 1000);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
